// File: rtl/pma_region_checker.sv
// Physical memory attribute checker: a programmable region table looked up through
// a two-stage pipeline (match snapshot, then priority encode) with a fault counter.
module pma_region_checker #(
  parameter int NREGIONS = 8,
  parameter int AW       = 32,
  parameter int GRAN     = 12,
  localparam int IW      = (NREGIONS > 1) ? $clog2(NREGIONS) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [AW-1:0] cfg_base,
  input  logic [AW-1:0] cfg_mask,
  input  logic [3:0]    cfg_attr,
  input  logic          cfg_lock,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [1:0]    req_cmd,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [AW-1:0] rsp_addr,
  output logic          rsp_hit,
  output logic          rsp_cacheable,
  output logic          rsp_fault,
  output logic [IW-1:0] rsp_region,
  output logic [7:0]    fault_count,
  input  logic          fault_clr
);

  localparam logic [AW-1:0] GRAN_MASK = ~((AW'(1) << GRAN) - AW'(1));

  function automatic logic [IW-1:0] first_idx(input logic [NREGIONS-1:0] m);
    first_idx = '0;
    for (int i = NREGIONS - 1; i >= 0; i--)
      if (m[i]) first_idx = IW'(i);
  endfunction

  function automatic logic access_fault(input logic hit, input logic [1:0] cmd,
                                        input logic w, input logic x);
    if (!hit) access_fault = 1'b1;
    else begin
      case (cmd)
        2'd1:    access_fault = !w;
        2'd2:    access_fault = !x;
        2'd3:    access_fault = 1'b1;
        default: access_fault = 1'b0;
      endcase
    end
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [AW-1:0]       base_q [NREGIONS];
  logic [AW-1:0]       mask_q [NREGIONS];
  logic [3:0]          attr_q [NREGIONS];
  logic [NREGIONS-1:0] lock_q;
  logic                cfg_sel;

  // A locked region ignores writes until the next reset.
  assign cfg_sel = cfg_we && (32'(cfg_idx) < NREGIONS) && !lock_q[cfg_idx];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGIONS; i++) begin
        base_q[i] <= '0;
        mask_q[i] <= '0;
        attr_q[i] <= '0;
      end
      lock_q <= '0;
    end else if (cfg_sel) begin
      base_q[cfg_idx] <= cfg_base;
      mask_q[cfg_idx] <= cfg_mask;
      attr_q[cfg_idx] <= cfg_attr;
      lock_q[cfg_idx] <= cfg_lock;
    end
  end

  logic [NREGIONS-1:0] match_d, c_d, w_d, x_d;

  always_comb begin
    match_d = '0;
    c_d     = '0;
    w_d     = '0;
    x_d     = '0;
    for (int i = 0; i < NREGIONS; i++) begin
      match_d[i] = attr_q[i][3] && (((req_addr ^ base_q[i]) & mask_q[i] & GRAN_MASK) == '0);
      c_d[i]     = attr_q[i][2];
      w_d[i]     = attr_q[i][1];
      x_d[i]     = attr_q[i][0];
    end
  end

  logic vld_p1, vld_p2, s2_free;

  assign s2_free   = !vld_p2 || rsp_ready;
  assign req_ready = !reset && (!vld_p1 || s2_free);

  // ---- stage 1: request and attribute snapshot ----
  logic [AW-1:0]       addr_p1;
  logic [1:0]          cmd_p1;
  logic [NREGIONS-1:0] match_p1, c_p1, w_p1, x_p1;

  always_ff @(posedge clock) begin
    if (reset) vld_p1 <= 1'b0;
    else if (req_ready) vld_p1 <= req_valid;
  end

  always_ff @(posedge clock) begin
    if (req_ready && req_valid) begin
      addr_p1  <= req_addr;
      cmd_p1   <= req_cmd;
      match_p1 <= match_d;
      c_p1     <= c_d;
      w_p1     <= w_d;
      x_p1     <= x_d;
    end
  end

  logic [IW-1:0] region_d;
  logic          hit_d, fault_d, cach_d;

  always_comb begin
    region_d = first_idx(match_p1);
    hit_d    = |match_p1;
    fault_d  = access_fault(hit_d, cmd_p1, w_p1[region_d], x_p1[region_d]);
    cach_d   = hit_d && c_p1[region_d] && !fault_d;
  end

  // ---- stage 2: priority-encoded result, held while the consumer stalls ----
  logic [AW-1:0] addr_p2;
  logic [IW-1:0] region_p2;
  logic          hit_p2, cach_p2, fault_p2;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p2    <= 1'b0;
      addr_p2   <= '0;
      region_p2 <= '0;
      hit_p2    <= 1'b0;
      cach_p2   <= 1'b0;
      fault_p2  <= 1'b0;
    end else if (s2_free) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        addr_p2   <= addr_p1;
        region_p2 <= region_d;
        hit_p2    <= hit_d;
        cach_p2   <= cach_d;
        fault_p2  <= fault_d;
      end
    end
  end

  assign rsp_valid     = vld_p2;
  assign rsp_addr      = addr_p2;
  assign rsp_region    = region_p2;
  assign rsp_hit       = hit_p2;
  assign rsp_cacheable = cach_p2;
  assign rsp_fault     = fault_p2;

  logic [7:0] fault_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) fault_cnt_q <= '0;
    else if (fault_clr) fault_cnt_q <= '0;
    else if (vld_p2 && rsp_ready && fault_p2) fault_cnt_q <= sat_inc(fault_cnt_q);
  end

  assign fault_count = fault_cnt_q;

endmodule

// File: doc/pma_region_checker.md
PMA_REGION_CHECKER -- requirements
Module: pma_region_checker

Interface
REQ-001 The block SHALL have parameter NREGIONS, default 8: number of programmable regions, range 1..16.
REQ-002 The block SHALL have parameter AW, default 32: address width.
REQ-003 The block SHALL have parameter GRAN, default 12: log2 of the minimum region size; mask bits below GRAN are ignored.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port: clock  in  1  sole clock; all state changes on its rising edge.
REQ-006 Port: reset  in  1  synchronous active-high reset.
REQ-007 Port: cfg_we  in  1  region table write strobe.
REQ-008 Port: cfg_idx  in  IW=max(1,clog2(NREGIONS))  region written.
REQ-009 Port: cfg_base, cfg_mask  in  AW each  region base and care-mask; a 1 bit means that bit is compared.
REQ-010 Port: cfg_attr  in  4  {en, c, w, x}: enable, cacheable, writable, executable; read is always permitted on a hit.
REQ-011 Port: cfg_lock  in  1  sets the region lock bit on write.
REQ-012 Port: req_valid/req_ready  in/out  1 each  lookup handshake.
REQ-013 Port: req_addr  in  AW; req_cmd  in  2  command: 0 read, 1 write, 2 fetch, 3 reserved.
REQ-014 Port: rsp_valid/rsp_ready  out/in  1 each  result handshake.
REQ-015 Port: rsp_addr  out  AW; rsp_hit, rsp_cacheable, rsp_fault  out  1 each; rsp_region  out  IW.
REQ-016 Port: fault_count  out  8; fault_clr  in  1.

Function
REQ-017 Region i SHALL match when en_i and ((req_addr ^ base_i) & mask_i & ~((1<<GRAN)-1)) == 0.
REQ-018 When several regions match, the lowest index SHALL win; rsp_region is that index and rsp_hit=1.
REQ-019 With no match: rsp_hit=0, rsp_region=0, rsp_cacheable=0, rsp_fault=1 (default deny).
REQ-020 On a hit, rsp_fault=1 only for cmd 1 with w=0, cmd 2 with x=0, or cmd 3; rsp_cacheable = c of the winning region, forced to 0 whenever rsp_fault=1.
REQ-021 Pipeline: S1 registers req_addr, req_cmd, the NREGIONS match vector and snapshot attributes; S2 registers the priority-encoded result. Latency is 2 cycles from the req accept to rsp_valid with no backpressure; throughput is 1 per cycle.
REQ-022 A stage SHALL advance when its successor is empty or is advancing; req_ready = !S1.valid | S1 advances; rsp_valid = S2.valid; combinational req_ready may depend on rsp_ready.
REQ-023 While rsp_valid=1 and rsp_ready=0, all rsp_* outputs SHALL hold stable.
REQ-024 A cfg_we write to a region whose lock bit is 1 SHALL be ignored entirely; lock clears only on reset.
REQ-025 A cfg write in cycle t SHALL affect lookups accepted at t+1 or later; lookups already in S1/S2 keep their snapshot.
REQ-026 A cfg_idx >= NREGIONS SHALL be ignored.
REQ-027 fault_count SHALL increment by 1 per response handshake (rsp_valid&rsp_ready) with rsp_fault=1 and saturate at 255.
REQ-028 fault_clr SHALL zero fault_count; if it coincides with an increment, the result is 0.
REQ-029 rsp_addr SHALL equal the accepted req_addr unchanged.

Reset
REQ-030 During reset: every region has en=0, lock=0, base=0, mask=0; S1/S2 are invalid; rsp_valid=0; req_ready=0; fault_count=0; all rsp_* data outputs are 0.
REQ-031 Reset asserted mid-operation SHALL discard in-flight lookups with no response; req_ready=1 from the first cycle after reset deasserts.

Verification
REQ-032 Region 0: base 0x8000_0000, mask 0xFFFE_0000, attr {1,1,1,1}; read 0x8001_0FFC -> 2 cycles later hit=1, region=0, cacheable=1, fault=0.
REQ-033 Regions 1 (0x4000_0000/0xFFFF_E000, w=0) and 3 (0x4000_0000/0xF000_0000, w=1); write 0x4000_0010 -> region=1, fault=1, cacheable=0, fault_count 0->1.
REQ-034 Empty table, fetch 0x0000_3000 -> hit=0, fault=1; 256 such faults -> fault_count=255; fault_clr -> 0.
REQ-035 Lock region 2, then rewrite region 2 with en=0 -> lookup at its base still hits region 2.
REQ-036 Stream 6 back-to-back reads with rsp_ready low for 3 cycles mid-stream -> no loss or reorder, outputs stable while stalled, req_ready drops after S1/S2 fill.
REQ-037 Reset asserted with 2 lookups in flight -> no rsp_valid after reset; table is cleared to disabled.
